// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises IF fetches and MEM data accesses onto one fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; by default the data port wins.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic avail_i, avail_d, d_wins, gnt, gnt_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  // In DONE only the port that did not just finish may be granted.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    avail_i    = if_req & ((state_q == IDLE) | ((state_q == DONE) & (owner_q == OWN_D)));
    avail_d    = d_req & ((state_q == IDLE) | ((state_q == DONE) & (owner_q == OWN_I)));
`ifdef ARB_ROUND_ROBIN_EN
    d_wins     = last_q == OWN_I;
`else
    d_wins     = 1'b1;
`endif
    gnt        = avail_i | avail_d;
    gnt_d      = avail_d & (~avail_i | d_wins);
    case (state_q)
      IDLE:  state_d = gnt ? ISSUE : IDLE;
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = 4'(MEM_LATENCY - 1);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          if_rdata_d = (owner_q == OWN_I) ? mem_rdata : if_rdata_q;
          d_rdata_d  = (owner_q == OWN_D) ? mem_rdata : d_rdata_q;
        end
      end
      DONE: begin
        state_d = gnt ? ISSUE : IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
    if (gnt) begin
      owner_d = gnt_d;
      addr_d  = gnt_d ? d_addr : if_addr;
      we_d    = gnt_d & d_we;
      wdata_d = gnt_d ? d_wdata : wdata_q;
    end
  end
  always_comb begin
    mem_en    = state_q == ISSUE;
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ready  = (state_q == DONE) & (owner_q == OWN_I);
    d_ready   = (state_q == DONE) & (owner_q == OWN_D);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    stall     = (if_req & ~if_ready) | (d_req & ~d_ready);
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench for unified_mem_arbiter with a latency-accurate memory model.
module tb_unified_mem_arbiter;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, if_req, d_req, d_we, if_ready, d_ready, mem_en, mem_we, stall;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic s1_req, s4_req;
  logic [31:0] s_addr;
  logic r1_ready, r4_ready, m1_en, m4_en, m1_we, m4_we, st1, st4, dr1, dr4;
  logic [31:0] r1_rdata, r4_rdata, m1_addr, m4_addr, mw1, mw4, m1_rdata, m4_rdata, dd1, dd4;
  int cyc = 0, en0 = -100, en1 = -100, en4 = -100;
  logic [31:0] a0 = '0, a1 = '0, a4 = '0, wa = '0, wd = '0;
  logic wvld = 1'b0;
  logic [31:0] junk;
  int n_chk = 0, n_fail = 0;
  exp_t qi[$];
  exp_t qd[$];
  logic got_i = 1'b0, got_d = 1'b0;
  logic [31:0] exp_drd = '0;
  int c0;
  unified_mem_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall));
  unified_mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .if_req(s1_req), .if_addr(s_addr), .if_rdata(r1_rdata), .if_ready(r1_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_rdata(dd1), .d_ready(dr1),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(mw1), .mem_rdata(m1_rdata),
    .stall(st1));
  unified_mem_arbiter #(.MEM_LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .if_req(s4_req), .if_addr(s_addr), .if_rdata(r4_rdata), .if_ready(r4_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_rdata(dd4), .d_ready(dr4),
    .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(mw4), .mem_rdata(m4_rdata),
    .stall(st4));
  // Read data is only valid exactly MEM_LATENCY cycles after the enable; junk otherwise.
  assign junk = 32'hBAD0_0000 | 32'(cyc);
  assign mem_rdata = (cyc != en0 + 2) ? junk : (wvld && a0 == wa) ? wd :
                     (a0 == 32'h100) ? 32'h2402_0005 : (32'h1000_0000 | a0);
  assign m1_rdata = (cyc == en1 + 1) ? {8'hA5, a1[23:0]} : junk;
  assign m4_rdata = (cyc == en4 + 4) ? {8'hA5, a4[23:0]} : junk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin en0 <= cyc; a0 <= mem_addr; end
    if (m1_en) begin en1 <= cyc; a1 <= m1_addr; end
    if (m4_en) begin en4 <= cyc; a4 <= m4_addr; end
    if (reset) wvld <= 1'b0;
    else if (mem_en && mem_we) begin wvld <= 1'b1; wa <= mem_addr; wd <= mem_wdata; end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mon();
    exp_t e;
    if (if_ready) begin
      got_i = 1'b1;
      chk("if_ready_expected", 32'(qi.size() > 0), 32'd1);
      if (qi.size() > 0) begin
        e = qi.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("stall_at_if_ready", 32'(stall), 32'(d_req));
      end
    end
    if (d_ready) begin
      got_d = 1'b1;
      chk("d_ready_expected", 32'(qd.size() > 0), 32'd1);
      if (qd.size() > 0) begin
        e = qd.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("stall_at_d_ready", 32'(stall), 32'(if_req));
      end
    end
  endtask
  task automatic smp();
    @(negedge clk);
    mon();
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
    if (got_i) if_req = 1'b0;
    if (got_d) d_req = 1'b0;
    got_i = 1'b0;
    got_d = 1'b0;
  endtask
  task automatic cyc1();
    smp();
    adv();
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n && (qi.size() > 0 || qd.size() > 0); i++) cyc1();
    chk("drain_outstanding", 32'(qi.size() + qd.size()), 32'd0);
  endtask
  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; s1_req = 1'b0; s4_req = 1'b0; s_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    smp();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ready", 32'({if_ready, d_ready}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    adv();
    reset = 1'b0;
    // Lone fetch
    if_req = 1'b1; if_addr = 32'h100; c0 = cyc;
    qi.push_back('{32'h2402_0005, c0 + 4});
    smp();
    chk("fetch_c0_stall", 32'(stall), 32'd1);
    chk("fetch_c0_mem_en", 32'(mem_en), 32'd0);
    adv();
    if_addr = 32'h200;
    smp();
    chk("fetch_c1_mem_en", 32'(mem_en), 32'd1);
    chk("fetch_c1_mem_we", 32'(mem_we), 32'd0);
    chk("fetch_c1_mem_addr", mem_addr, 32'h100);
    chk("fetch_c1_stall", 32'(stall), 32'd1);
    adv();
    drain(10);
    // Contention: data load and fetch together
    if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; c0 = cyc;
    qd.push_back('{32'h1000_0080, c0 + 4});
    qi.push_back('{32'h1000_0104, c0 + 8});
    exp_drd = 32'h1000_0080;
    smp();
    adv();
    smp();
    chk("cont_c1_mem_addr", mem_addr, 32'h80);
    adv();
    repeat (3) cyc1();
    smp();
    chk("cont_c5_mem_en", 32'(mem_en), 32'd1);
    chk("cont_c5_mem_addr", mem_addr, 32'h104);
    adv();
    drain(10);
    // Store; inputs changed after grant must be ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; c0 = cyc;
    qd.push_back('{exp_drd, c0 + 2});
    cyc1();
    d_wdata = 32'h0; d_addr = 32'h44;
    smp();
    chk("store_mem_en", 32'(mem_en), 32'd1);
    chk("store_mem_we", 32'(mem_we), 32'd1);
    chk("store_mem_addr", mem_addr, 32'h40);
    chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    adv();
    drain(10);
    // Second contention, last owner is the data port
    d_we = 1'b0; d_addr = 32'h40; if_addr = 32'h108; if_req = 1'b1; d_req = 1'b1; c0 = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    qi.push_back('{32'h1000_0108, c0 + 4});
    qd.push_back('{32'hDEAD_BEEF, c0 + 8});
`else
    qd.push_back('{32'hDEAD_BEEF, c0 + 4});
    qi.push_back('{32'h1000_0108, c0 + 8});
`endif
    drain(15);
    // Reset in the first WAIT cycle of a fetch
    if_req = 1'b1; if_addr = 32'h10C;
    cyc1();
    cyc1();
    reset = 1'b1;
    cyc1();
    reset = 1'b0; if_req = 1'b0;
    smp();
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_if_ready", 32'(if_ready), 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    adv();
    repeat (5) begin
      smp();
      chk("midrst_quiet_mem_en", 32'(mem_en), 32'd0);
      adv();
    end
    // Latency sweep: MEM_LATENCY 1 and 4
    s1_req = 1'b1; s4_req = 1'b1; s_addr = 32'h0123_4560;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("lat1_ready", 32'(r1_ready), 32'(k == 3));
      chk("lat4_ready", 32'(r4_ready), 32'(k == 6));
      chk("lat1_rdata", r1_rdata, (k >= 3) ? 32'hA523_4560 : 32'h0);
      chk("lat4_rdata", r4_rdata, (k >= 6) ? 32'hA523_4560 : 32'h0);
      adv();
      if (k == 3) s1_req = 1'b0;
      if (k == 6) s4_req = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the IF-stage instruction fetch port and the MEM-stage data port of the pipelined CPU.
- Serialises accesses through a small FSM and returns per-port one-cycle ready pulses with registered read data.
- Drives a pipeline stall while any port has an outstanding request.
- Sits between the pipeline and the memory, replacing direct instruction/data memory hookup.

Parameters:
- ADDR_W, 32, address width for both ports and memory
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from a memory enable cycle to a valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ready  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
- stall  out  1  pipeline stall

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- States: IDLE, ISSUE, WAIT, DONE. Registers: owner (I/D), latched addr/wdata/we, counter (4 bits), if_rdata, d_rdata, last_owner.
- Reset values:
  - state = IDLE; all ready pulses, mem_en and mem_we = 0
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0
  - last_owner = I
- IDLE: if any request is pending, grant it per the priority rule, latch that port's addr/wdata/we (a fetch latches we = 0), then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
  - A write goes to DONE.
  - A read loads counter = MEM_LATENCY-1 and goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register, then go to DONE.
  - WAIT therefore lasts exactly MEM_LATENCY cycles.
- DONE (1 cycle):
  - Owner's ready = 1; last_owner = owner.
  - The finishing port's request is ignored this cycle.
  - If the other port is requesting, grant it (latch) and go to ISSUE; otherwise go to IDLE.
- Latency, counted from a request sampled in IDLE at cycle 0:
  - read: ready in cycle MEM_LATENCY+2
  - write: ready in cycle 2
- Port inputs that change while a port is owned (ISSUE/WAIT/DONE) are ignored; only the values latched at grant are used.
- The rdata registers hold their value until the same port's next read completes; a write does not alter d_rdata.
- stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinational; low in the ready cycle so the pipeline advances on that edge.
- Reset mid-access:
  - Abort to IDLE next cycle, with no ready pulse and no further mem_en.
  - An in-flight memory read result is discarded.
- Simultaneous requests: resolved by the priority rule; the loser waits without losing its request.
- Idle with no requests: mem_en = 0; mem_addr and mem_wdata hold their last value.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Without the macro: when both ports request in the same grant cycle, the data port always wins, because the MEM stage is the older instruction.
- With the macro defined: when both request, the port not equal to last_owner wins. A lone requester is always granted. Since last_owner resets to I, the first contested grant goes to D.

Test Plan:
- Fetch only, MEM_LATENCY=2: if_req=1, if_addr=0x100, memory returns 0x2402_0005 → mem_en pulses in cycle 1 with addr 0x100; if_ready in cycle 4; if_rdata = 0x2402_0005; stall high in cycles 0-3.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF → mem_en=mem_we=1 in cycle 1 with that addr/data; d_ready in cycle 2; d_rdata unchanged.
- Contention, default build: if_req and d_req (load 0x80) both rise in cycle 0 → data is served first (d_ready cycle 4); fetch is granted in the DONE cycle with mem_en in cycle 5 and if_ready in cycle 8.
- Contention with ARB_ROUND_ROBIN_EN, three back-to-back contested grants with both requests re-asserted → service order D, I, D.
- Reset asserted in the first WAIT cycle of a read → next cycle: state IDLE, no ready pulse, mem_en=0, rdata registers = 0.
- Sweep MEM_LATENCY=1 and MEM_LATENCY=4: read ready in cycles 3 and 6 respectively; mem_rdata is captured only on its valid cycle, and wrong data driven on other cycles is not captured.
